// File: rtl/pacman_pkg.sv
// Shared types and default keycodes for the Pac-Man / ghost sprite controllers.
package pacman_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    LEFT  = 2'd1,
    DOWN  = 2'd2,
    RIGHT = 2'd3
  } dir_t;

  typedef enum logic {
    STOPPED = 1'b0,
    MOVING  = 1'b1
  } state_t;

  // Pac-Man player keycodes (W/A/S/D style mapping from keycode_pacman)
  localparam logic [7:0] PACMAN_KEY_UP    = 8'h1A;
  localparam logic [7:0] PACMAN_KEY_LEFT  = 8'h04;
  localparam logic [7:0] PACMAN_KEY_DOWN  = 8'h16;
  localparam logic [7:0] PACMAN_KEY_RIGHT = 8'h07;

  // Ghost player keycodes (arrow keys from keycode_ghost)
  localparam logic [7:0] GHOST_KEY_UP    = 8'h52;
  localparam logic [7:0] GHOST_KEY_LEFT  = 8'h50;
  localparam logic [7:0] GHOST_KEY_DOWN  = 8'h51;
  localparam logic [7:0] GHOST_KEY_RIGHT = 8'h4F;

endpackage

// File: rtl/keycode_to_dir.sv
// Combinational keycode decoder: turns one of four keycodes into a direction
// request. Also used by the ghost AI override logic.
module keycode_to_dir
  import pacman_pkg::*;
#(
  parameter logic [7:0] KEY_UP    = PACMAN_KEY_UP,
  parameter logic [7:0] KEY_LEFT  = PACMAN_KEY_LEFT,
  parameter logic [7:0] KEY_DOWN  = PACMAN_KEY_DOWN,
  parameter logic [7:0] KEY_RIGHT = PACMAN_KEY_RIGHT
) (
  input  logic [7:0] keycode,
  output logic       req_valid,
  output logic [1:0] req_dir
);

  // Match the keycode against the four direction keys; anything else is "no key"
  always_comb begin
    req_valid = 1'b1;
    req_dir   = UP;
    if (keycode == KEY_UP) begin
      req_dir = UP;
    end else if (keycode == KEY_LEFT) begin
      req_dir = LEFT;
    end else if (keycode == KEY_DOWN) begin
      req_dir = DOWN;
    end else if (keycode == KEY_RIGHT) begin
      req_dir = RIGHT;
    end else begin
      req_valid = 1'b0;
    end
  end

endmodule

// File: rtl/keycode_dir_controller.sv
// Sprite direction controller: buffers a requested turn until the sprite can
// legally take it, applies turns only on frame ticks, and stops at walls.
module keycode_dir_controller
  import pacman_pkg::*;
#(
  parameter logic [7:0] KEY_UP      = PACMAN_KEY_UP,
  parameter logic [7:0] KEY_LEFT    = PACMAN_KEY_LEFT,
  parameter logic [7:0] KEY_DOWN    = PACMAN_KEY_DOWN,
  parameter logic [7:0] KEY_RIGHT   = PACMAN_KEY_RIGHT,
  parameter int         HOLD_FRAMES = 8
) (
  input  logic       vga_clk,
  input  logic       Reset,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic [3:0] blocked,
  output logic [1:0] dir,
  output logic       moving,
  output logic       pending_valid,
  output logic [1:0] pending_dir,
  output logic       turn_pulse
);

  localparam int AGE_W = $clog2(HOLD_FRAMES + 1);
  localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(HOLD_FRAMES - 1);
  localparam logic [AGE_W-1:0] AGE_MAX  = '1;

  logic       req_valid;
  logic [1:0] req_dir;

  state_t           state_q, state_d;
  dir_t             dir_q, dir_d;
  logic             pending_valid_q, pending_valid_d;
  dir_t             pending_dir_q, pending_dir_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic             turn_pulse_q, turn_pulse_d;
  logic [3:0]       blocked_q;

  keycode_to_dir #(
    .KEY_UP    (KEY_UP),
    .KEY_LEFT  (KEY_LEFT),
    .KEY_DOWN  (KEY_DOWN),
    .KEY_RIGHT (KEY_RIGHT)
  ) u_decode (
    .keycode   (keycode),
    .req_valid (req_valid),
    .req_dir   (req_dir)
  );

  // Next-state: tick-gated turn/stop/age decision on the old pending, then a key reloads the buffer
  always_comb begin
    state_d         = state_q;
    dir_d           = dir_q;
    pending_valid_d = pending_valid_q;
    pending_dir_d   = pending_dir_q;
    age_d           = age_q;
    turn_pulse_d    = 1'b0;

    if (frame_tick) begin
      if (pending_valid_q && !blocked_q[pending_dir_q]) begin
        dir_d           = pending_dir_q;
        state_d         = MOVING;
        pending_valid_d = 1'b0;
        age_d           = '0;
        turn_pulse_d    = (pending_dir_q != dir_q) || (state_q == STOPPED);
      end else if ((state_q == MOVING) && blocked_q[dir_q]) begin
        state_d = STOPPED;
      end else if (pending_valid_q && !req_valid) begin
        if (age_q == AGE_LAST) begin
          pending_valid_d = 1'b0;
          age_d           = '0;
        end else if (age_q != AGE_MAX) begin
          age_d = age_q + 1'b1;
        end
      end
    end

    if (req_valid) begin
      pending_valid_d = 1'b1;
      pending_dir_d   = dir_t'(req_dir);
      age_d           = '0;
    end
  end

  // State, request buffer, age counter and wall snapshot registers
  always_ff @(posedge vga_clk) begin
    if (Reset) begin
      state_q         <= STOPPED;
      dir_q           <= LEFT;
      pending_valid_q <= 1'b0;
      pending_dir_q   <= UP;
      age_q           <= '0;
      turn_pulse_q    <= 1'b0;
      blocked_q       <= '0;
    end else begin
      state_q         <= state_d;
      dir_q           <= dir_d;
      pending_valid_q <= pending_valid_d;
      pending_dir_q   <= pending_dir_d;
      age_q           <= age_d;
      turn_pulse_q    <= turn_pulse_d;
      blocked_q       <= blocked;
    end
  end

  assign dir           = dir_q;
  assign moving        = (state_q == MOVING);
  assign pending_valid = pending_valid_q;
  assign pending_dir   = pending_dir_q;
  assign turn_pulse    = turn_pulse_q;

endmodule
